// File: rtl/psum_pkg.sv
// Shared definitions for the partial-sum buffer sequencer.
package psum_pkg;

    // Row sequencing states, in the order a row walks through them.
    typedef enum logic [2:0] {
        PSUM_ST_IDLE  = 3'd0,
        PSUM_ST_INIT  = 3'd1,
        PSUM_ST_ACCUM = 3'd2,
        PSUM_ST_FLUSH = 3'd3,
        PSUM_ST_DRAIN = 3'd4,
        PSUM_ST_DONE  = 3'd5
    } psum_state_e;

    // Adder-tree latency between an accumulate strobe and the FIFO write.
    localparam int PSUM_PIPE_LAT = 3;

    // Depth of the psum FIFO; the element counters must be able to reach it.
    localparam int PSUM_FIFO_DEPTH = 61;

endpackage

// File: rtl/psum_ctrl.sv
// Sequencer for the conv-kernel partial-sum buffer: zero-fills the FIFO,
// runs the accumulation passes, then drains the final sums downstream.
module psum_ctrl
    import psum_pkg::*;
#(
    parameter int ADDR_W   = 8,
    parameter int PASS_W   = 8,
    parameter int PIPE_LAT = PSUM_PIPE_LAT
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              abort,
    input  logic [ADDR_W-1:0] cfg_row_len,
    input  logic [PASS_W-1:0] cfg_passes,
    input  logic              pe_valid,
    output logic              pe_ready,
    input  logic              out_ready,
    output logic              p_init,
    output logic              p_valid_data,
    output logic              p_write_zero,
    output logic              odd_cnt,
    output logic              busy,
    output logic              done
);

    // Flush counter is at least 2 bits wide, wider only for long adder trees.
    localparam int LAT_W = (PIPE_LAT > 4) ? $clog2(PIPE_LAT) : 2;
    localparam logic [LAT_W-1:0] LAT_LAST = LAT_W'(PIPE_LAT - 1);

    psum_state_e       state;
    logic [ADDR_W-1:0] row_len;
    logic [ADDR_W-1:0] elem_cnt;
    logic [PASS_W-1:0] passes;
    logic [PASS_W-1:0] pass_cnt;
    logic [LAT_W-1:0]  lat_cnt;
    logic              odd_q;
    logic              elem_last;
    logic              pass_last;

    assign elem_last = (elem_cnt == (row_len - ADDR_W'(1)));
    assign pass_last = (pass_cnt == (passes - PASS_W'(1)));

    // Row FSM and its element / pass / flush counters.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= PSUM_ST_IDLE;
            row_len  <= '0;
            passes   <= '0;
            elem_cnt <= '0;
            pass_cnt <= '0;
            lat_cnt  <= '0;
            odd_q    <= 1'b0;
        end else if (abort) begin
            // Abort returns to a clean idle; the next row re-inits the FIFO anyway.
            state    <= PSUM_ST_IDLE;
            elem_cnt <= '0;
            pass_cnt <= '0;
            lat_cnt  <= '0;
            odd_q    <= 1'b0;
        end else begin
            case (state)
                PSUM_ST_IDLE: begin
                    if (start) begin
                        row_len  <= cfg_row_len;
                        // Zero passes would never reach the drain; run one instead.
                        passes   <= (cfg_passes == '0) ? PASS_W'(1) : cfg_passes;
                        elem_cnt <= '0;
                        pass_cnt <= '0;
                        lat_cnt  <= '0;
                        odd_q    <= 1'b0;
                        state    <= (cfg_row_len == '0) ? PSUM_ST_DONE : PSUM_ST_INIT;
                    end
                end
                PSUM_ST_INIT: begin
                    if (elem_last) begin
                        elem_cnt <= '0;
                        state    <= PSUM_ST_ACCUM;
                    end else begin
                        elem_cnt <= elem_cnt + ADDR_W'(1);
                    end
                end
                PSUM_ST_ACCUM: begin
                    if (pe_valid) begin
                        if (elem_last) begin
                            elem_cnt <= '0;
                            lat_cnt  <= '0;
                            state    <= PSUM_ST_FLUSH;
                        end else begin
                            elem_cnt <= elem_cnt + ADDR_W'(1);
                        end
                    end
                end
                PSUM_ST_FLUSH: begin
                    // Wait out the adder tree so the last sum lands before it is re-read.
                    if (lat_cnt == LAT_LAST) begin
                        lat_cnt <= '0;
                        if (pass_last) begin
                            state <= PSUM_ST_DRAIN;
                        end else begin
                            pass_cnt <= pass_cnt + PASS_W'(1);
                            odd_q    <= ~odd_q;
                            state    <= PSUM_ST_ACCUM;
                        end
                    end else begin
                        lat_cnt <= lat_cnt + LAT_W'(1);
                    end
                end
                PSUM_ST_DRAIN: begin
                    if (out_ready) begin
                        if (elem_last) begin
                            elem_cnt <= '0;
                            state    <= PSUM_ST_DONE;
                        end else begin
                            elem_cnt <= elem_cnt + ADDR_W'(1);
                        end
                    end
                end
                PSUM_ST_DONE: begin
                    state <= PSUM_ST_IDLE;
                end
                default: begin
                    state <= PSUM_ST_IDLE;
                end
            endcase
        end
    end

    // Strobes decode the state register; the data handshakes pass straight
    // through so the buffer sees them in the same cycle, and abort blanks them.
    assign pe_ready     = (state == PSUM_ST_ACCUM);
    assign p_init       = (state == PSUM_ST_INIT)  && !abort;
    assign p_valid_data = (state == PSUM_ST_ACCUM) && pe_valid  && !abort;
    assign p_write_zero = (state == PSUM_ST_DRAIN) && out_ready && !abort;
    assign odd_cnt      = odd_q;
    assign busy         = (state != PSUM_ST_IDLE);
    assign done         = (state == PSUM_ST_DONE)  && !abort;

    // The buffer can only perform one kind of access per cycle.
    always @(posedge clk) begin
        if (rst_n) begin
            assert ($onehot0({p_init, p_valid_data, p_write_zero}));
        end
    end

endmodule
